// File: rtl/lsu_ctrl_pkg.sv
// Shared types and decode helpers for the MEM-stage load/store controller.
package LsuPkg;
  localparam int DATA_W = 32;
  localparam int OFF_W  = 2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, RMW_WRITE} lsu_state_t;

  // Stores only have signed-size encodings; BU/HU on a store is a no-op.
  function automatic logic f3_supported(input logic [2:0] f3, input logic we);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [OFF_W-1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Low offset bits that survive forced alignment for each access size.
  function automatic logic [OFF_W-1:0] align_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b01:   return 2'b10;
      2'b10:   return 2'b00;
      default: return 2'b11;
    endcase
  endfunction
endpackage

// File: rtl/lsu_ctrl_byte_lane.sv
// Combinational byte-lane logic: load extract/extend and sub-word store merge.
module lsu_byte_lane
  import LsuPkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [OFF_W-1:0]  offset,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] new_data,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merged
);
  logic [DATA_W-1:0] shifted;

  always_comb begin
    shifted = word >> {offset, 3'b000};
    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_data = {24'h0, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_data = {16'h0, shifted[15:0]};
      default: load_data = word;
    endcase
  end

  always_comb begin
    merged = word;
    case (funct3)
      F3_B:    merged[{offset, 3'b000} +: 8]         = new_data[7:0];
      F3_H:    merged[{offset[1], 4'b0000} +: 16]    = new_data[15:0];
      default: merged = new_data;
    endcase
  end
endmodule

// File: rtl/lsu_ctrl.sv
// RV32I load/store controller driving a word-wide, 1-cycle-latency data memory.
// Define LSU_MISALIGN_CHECK_EN to trap misaligned accesses instead of force-aligning them.
module lsu_ctrl
  import LsuPkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  input  logic                  i_req_we,
  input  logic [2:0]            i_funct3,
  input  logic [31:0]           i_addr,
  input  logic [31:0]           i_wdata,
  output logic                  o_dmem_we,
  output logic [ADDR_WIDTH-1:0] o_dmem_addr,
  output logic [31:0]           o_dmem_wdata,
  input  logic [31:0]           i_dmem_rdata,
  output logic [31:0]           o_load_data,
  output logic                  o_load_valid,
  output logic                  o_stall,
  output logic                  o_misaligned
);
  if (DATA_WIDTH != 32) begin : g_width_check
    $error("lsu_ctrl supports DATA_WIDTH = 32 only");
  end

  lsu_state_t            state;
  logic [OFF_W-1:0]      lat_off;
  logic [2:0]            lat_f3;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [31:0]           lat_wdata;

  logic                  supported, mis, go, go_load, go_rmw;
  logic [OFF_W-1:0]      off_eff;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [31:0]           lane_load, lane_merged;
  logic                  unused_addr;

  assign unused_addr = ^i_addr[31:ADDR_WIDTH+2];
  assign word_addr   = i_addr[ADDR_WIDTH+1:2];
  assign supported   = f3_supported(i_funct3, i_req_we);

`ifdef LSU_MISALIGN_CHECK_EN
  assign mis     = is_misaligned(i_funct3, i_addr[1:0]);
  assign off_eff = i_addr[1:0];
`else
  assign mis     = 1'b0;
  assign off_eff = i_addr[1:0] & align_mask(i_funct3);
`endif

  assign go      = (state == IDLE) && i_req_valid && supported && !mis;
  assign go_load = go && !i_req_we;
  assign go_rmw  = go && i_req_we && (i_funct3 != F3_W);

  lsu_byte_lane u_lane (
    .word      (i_dmem_rdata),
    .offset    (lat_off),
    .funct3    (lat_f3),
    .new_data  (lat_wdata),
    .load_data (lane_load),
    .merged    (lane_merged)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      lat_off   <= '0;
      lat_f3    <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            lat_off   <= off_eff;
            lat_f3    <= i_funct3;
            lat_addr  <= word_addr;
            lat_wdata <= i_wdata;
          end
          if (go_load)     state <= LOAD_WAIT;
          else if (go_rmw) state <= RMW_WRITE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from the live request so the read address reaches memory in T.
  always_comb begin
    o_dmem_we    = 1'b0;
    o_dmem_addr  = '0;
    o_dmem_wdata = '0;
    o_load_data  = '0;
    o_load_valid = 1'b0;
    o_stall      = 1'b0;
    o_misaligned = 1'b0;
    if (!i_rst) begin
      case (state)
        IDLE: begin
          if (i_req_valid && supported) begin
            if (mis) begin
              o_misaligned = 1'b1;
            end else begin
              o_dmem_addr = word_addr;
              if (i_req_we && i_funct3 == F3_W) begin
                o_dmem_we    = 1'b1;
                o_dmem_wdata = i_wdata;
              end else begin
                o_stall = 1'b1;
              end
            end
          end
        end
        LOAD_WAIT: begin
          o_dmem_addr  = lat_addr;
          o_load_valid = 1'b1;
          o_load_data  = lane_load;
        end
        RMW_WRITE: begin
          o_dmem_addr  = lat_addr;
          o_dmem_we    = 1'b1;
          o_dmem_wdata = lane_merged;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl with a 1-cycle-latency word memory model.
module tb_lsu_ctrl;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst, preload;
  logic          req_valid, req_we;
  logic [2:0]    funct3;
  logic [31:0]   addr, wdata;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_wdata, dmem_rdata, load_data;
  logic          load_valid, stall, misaligned;

  logic [31:0] mem [0:511];

  typedef struct {
    int          kind;   // 0 load, 1 write, 2 misaligned
    logic [31:0] data;
    logic [8:0]  waddr;
  } exp_t;
  exp_t q[$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .i_req_we     (req_we),
    .i_funct3     (funct3),
    .i_addr       (addr),
    .i_wdata      (wdata),
    .o_dmem_we    (dmem_we),
    .o_dmem_addr  (dmem_addr),
    .o_dmem_wdata (dmem_wdata),
    .i_dmem_rdata (dmem_rdata),
    .o_load_data  (load_data),
    .o_load_valid (load_valid),
    .o_stall      (stall),
    .o_misaligned (misaligned)
  );

  always @(posedge clk) begin
    dmem_rdata <= mem[dmem_addr];
    if (preload) mem[16] <= 32'h8899AABB;
    else if (dmem_we) mem[dmem_addr] <= dmem_wdata;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (load_valid || dmem_we || misaligned) begin
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_output: we=%b load_valid=%b misaligned=%b with nothing expected",
                 dmem_we, load_valid, misaligned);
      end else begin
        exp_t e;
        int   kind;
        e    = q.pop_front();
        kind = misaligned ? 2 : (dmem_we ? 1 : 0);
        chk("event_kind", kind, e.kind);
        if (e.kind == 0) chk("load_data", load_data, e.data);
        if (e.kind == 1) begin
          chk("write_addr", {23'h0, dmem_addr}, {23'h0, e.waddr});
          chk("write_data", dmem_wdata, e.data);
        end
      end
    end
  end

  task automatic exp_load(input logic [31:0] d);
    q.push_back('{kind: 0, data: d, waddr: 9'h0});
  endtask
  task automatic exp_write(input logic [8:0] a, input logic [31:0] d);
    q.push_back('{kind: 1, data: d, waddr: a});
  endtask
  task automatic exp_mis();
    q.push_back('{kind: 2, data: 32'h0, waddr: 9'h0});
  endtask

  // Holds the request for ncyc cycles; a 2-cycle op must stall only in its first cycle.
  task automatic issue(input string nm, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input int ncyc);
    req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      chk({nm, "_stall"}, {31'h0, stall}, {31'h0, (c == 0 && ncyc == 2)});
      if (c == 0 && ncyc == 2) chk({nm, "_we_T"}, {31'h0, dmem_we}, 32'h0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; preload = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b010; addr = 32'h40; wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("rst_ctrl", {28'h0, dmem_we, stall, load_valid, misaligned}, 32'h0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_addr", {23'h0, dmem_addr}, 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; preload = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("idle_ctrl", {28'h0, dmem_we, stall, load_valid, misaligned}, 32'h0);
    @(posedge clk); #1;

    exp_load(32'hFFFF_FFAA); issue("lb_41",  1'b0, 3'b000, 32'h41, 32'h0, 2);
    exp_load(32'h0000_0088); issue("lbu_43", 1'b0, 3'b100, 32'h43, 32'h0, 2);
    exp_load(32'h0000_8899); issue("lhu_42", 1'b0, 3'b101, 32'h42, 32'h0, 2);
    exp_load(32'hFFFF_AABB); issue("lh_40",  1'b0, 3'b001, 32'h40, 32'h0, 2);
    exp_load(32'h8899_AABB); issue("lw_40",  1'b0, 3'b010, 32'h40, 32'h0, 2);

    exp_write(9'h010, 32'h1234_AABB); issue("sh_42", 1'b1, 3'b001, 32'h42, 32'h0000_1234, 2);
    exp_load(32'h1234_AABB);          issue("lw_40b", 1'b0, 3'b010, 32'h40, 32'h0, 2);
    exp_write(9'h011, 32'hDEAD_BEEF); issue("sw_44", 1'b1, 3'b010, 32'h44, 32'hDEAD_BEEF, 1);
    exp_load(32'hDEAD_BEEF);          issue("lw_44", 1'b0, 3'b010, 32'h44, 32'h0, 2);

`ifdef LSU_MISALIGN_CHECK_EN
    exp_mis();               issue("lh_41", 1'b0, 3'b001, 32'h41, 32'h0, 1);
`else
    exp_load(32'hFFFF_AABB); issue("lh_41", 1'b0, 3'b001, 32'h41, 32'h0, 2);
`endif

    exp_write(9'h010, 32'h8899_AABB); issue("sw_40", 1'b1, 3'b010, 32'h40, 32'h8899_AABB, 1);

    // SB aborted by reset in its write cycle.
    req_valid = 1'b1; req_we = 1'b1; funct3 = 3'b000; addr = 32'h40; wdata = 32'h77;
    @(negedge clk);
    chk("sb_abort_stall_T", {31'h0, stall}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("sb_abort_we", {31'h0, dmem_we}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("after_abort_ctrl", {28'h0, dmem_we, stall, load_valid, misaligned}, 32'h0);
    chk("after_abort_data", load_data | dmem_wdata | {23'h0, dmem_addr}, 32'h0);
    chk("after_abort_mem", mem[16], 32'h8899_AABB);
    @(posedge clk); #1;
    exp_load(32'h8899_AABB); issue("lw_after_abort", 1'b0, 3'b010, 32'h40, 32'h0, 2);

    issue("unsup_011", 1'b0, 3'b011, 32'h40, 32'h0, 1);
    issue("unsup_110", 1'b1, 3'b110, 32'h40, 32'h55, 1);

    exp_write(9'h010, 32'h5599_AABB); issue("sb_43", 1'b1, 3'b000, 32'h43, 32'h0000_0055, 2);
    exp_load(32'h0000_0055);          issue("lb_43", 1'b0, 3'b000, 32'h43, 32'h0, 2);
    exp_load(32'h5599_AABB);          issue("lw_wrap", 1'b0, 3'b010, 32'h840, 32'h0, 2);

`ifdef LSU_MISALIGN_CHECK_EN
    exp_mis();                        issue("sw_46", 1'b1, 3'b010, 32'h46, 32'hCAFE_F00D, 1);
    exp_load(32'hDEAD_BEEF);          issue("lw_44b", 1'b0, 3'b010, 32'h44, 32'h0, 2);
`else
    exp_write(9'h011, 32'hCAFE_F00D); issue("sw_46", 1'b1, 3'b010, 32'h46, 32'hCAFE_F00D, 1);
    exp_load(32'hCAFE_F00D);          issue("lw_44b", 1'b0, 3'b010, 32'h44, 32'h0, 2);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
